// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for its data-memory response,
// buffers it across WB stalls, and discards responses orphaned by a flush.
module mem_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         es_to_ms_valid,
    input  logic [118:0] es_to_ms_bus,
    output logic         ms_allowin,
    input  logic         data_data_ok,
    input  logic [31:0]  data_rdata,
    input  logic         ws_allowin,
    output logic         ms_to_ws_valid,
    output logic [149:0] ms_to_ws_bus,
    output logic [4:0]   MEM_dest,
    output logic [31:0]  MEM_result,
    output logic         ms_load_stall,
    output logic         ms_ex
);

    logic         ms_valid;
    logic [118:0] bus_r;
    logic         rbuf_valid;
    logic [31:0]  rbuf;
    logic [1:0]   cancel_cnt;

    logic         mem_req;
    logic         res_from_mem;
    logic [11:0]  mem_inst;
    logic [31:0]  rt_value;
    logic [1:0]   rdata_type;
    logic         ex;
    logic         gr_we;
    logic [4:0]   dest;
    logic [31:0]  result;
    logic [31:0]  pc;

    logic         own_resp;
    logic         stale_resp;
    logic         got_data;
    logic         ms_ready_go;
    logic         handoff;
    logic         buffer_resp;
    logic         cancel_inc;
    logic [31:0]  ms_data;

    assign {mem_req, res_from_mem, mem_inst, rt_value, rdata_type,
            ex, gr_we, dest, result, pc} = bus_r;

    // A response belongs to the current instruction only once every
    // response owed to previously flushed requests has drained.
    assign own_resp    = data_data_ok & (cancel_cnt == 2'd0);
    assign stale_resp  = data_data_ok & (cancel_cnt != 2'd0);
    assign got_data    = rbuf_valid | own_resp;
    assign ms_ready_go = ~mem_req | got_data;

    assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go & ~flush;
    assign handoff        = ms_to_ws_valid & ws_allowin;

    assign buffer_resp = own_resp & ms_valid & mem_req & ~rbuf_valid & ~ws_allowin & ~flush;
    assign cancel_inc  = flush & ms_valid & mem_req & ~got_data;

    assign ms_data = rbuf_valid ? rbuf : data_rdata;

    assign ms_to_ws_bus = {res_from_mem, mem_inst, rt_value, ms_data, rdata_type,
                           ex, gr_we, dest, result, pc};

    assign MEM_dest      = dest & {5{ms_valid}};
    assign MEM_result    = result;
    assign ms_load_stall = ms_valid & res_from_mem;
    assign ms_ex         = ms_valid & ex;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (flush) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_r <= '0;
        end else if (es_to_ms_valid & ms_allowin & ~flush) begin
            bus_r <= es_to_ms_bus;
        end
    end

    // Holds a response that arrived while WB could not take it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rbuf_valid <= 1'b0;
            rbuf       <= '0;
        end else if (flush | handoff) begin
            rbuf_valid <= 1'b0;
        end else if (buffer_resp) begin
            rbuf_valid <= 1'b1;
            rbuf       <= data_rdata;
        end
    end

    // Counts responses still owed to requests whose instruction was flushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            cancel_cnt <= 2'd0;
        end else begin
            case ({cancel_inc, stale_resp})
                2'b10: begin
                    if (cancel_cnt != 2'd3) begin
                        cancel_cnt <= cancel_cnt + 2'd1;
                    end
                end
                2'b01:   cancel_cnt <= cancel_cnt - 2'd1;
                default: cancel_cnt <= cancel_cnt;
            endcase
        end
    end

    cancel_cnt_never_saturates: assert property (
        @(posedge clk) disable iff (reset) cancel_cnt != 2'd3
    );

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus randomized traffic checked
// against a transaction-level model of EX, data memory and WB.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         es_to_ms_valid;
    logic [118:0] es_to_ms_bus;
    logic         ms_allowin;
    logic         data_data_ok;
    logic [31:0]  data_rdata;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [149:0] ms_to_ws_bus;
    logic [4:0]   MEM_dest;
    logic [31:0]  MEM_result;
    logic         ms_load_stall;
    logic         ms_ex;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          ready;
    } resp_t;

    mem_stage dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .es_to_ms_valid (es_to_ms_valid),
        .es_to_ms_bus   (es_to_ms_bus),
        .ms_allowin     (ms_allowin),
        .data_data_ok   (data_data_ok),
        .data_rdata     (data_rdata),
        .ws_allowin     (ws_allowin),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ms_to_ws_bus   (ms_to_ws_bus),
        .MEM_dest       (MEM_dest),
        .MEM_result     (MEM_result),
        .ms_load_stall  (ms_load_stall),
        .ms_ex          (ms_ex)
    );

    always #5 clk = ~clk;

    function automatic logic [118:0] make_es(input logic mreq, input logic rfm,
                                             input logic [4:0] dest, input logic [31:0] res,
                                             input logic ex, input logic we);
        logic [11:0] mi;
        logic [31:0] rt;
        logic [1:0]  rtype;
        logic [31:0] pc;
        mi    = 12'($urandom);
        rt    = $urandom;
        rtype = 2'($urandom);
        pc    = $urandom;
        return {mreq, rfm, mi, rt, rtype, ex, we, dest, res, pc};
    endfunction

    // Field layout toward WB, MSB first, with the memory data inserted.
    function automatic logic [149:0] make_ws(input logic [118:0] b, input logic [31:0] d);
        return {b[117], b[116:105], b[104:73], d, b[72:71], b[70], b[69],
                b[68:64], b[63:32], b[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush          = 1'b0;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus   = '0;
        data_data_ok   = 1'b0;
        data_rdata     = '0;
        ws_allowin     = 1'b1;
    endtask

    task automatic test_reset();
        logic [118:0] ld;
        idle_inputs();
        ld = make_es(1'b1, 1'b1, 5'd7, 32'h77, 1'b0, 1'b1);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = ld;
        tick();
        es_to_ms_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = make_es(1'b0, 1'b0, 5'd9, 32'h99, 1'b1, 1'b1);
        ws_allowin = 1'b0;
        tick();
        es_to_ms_valid = 1'b0;
        reset = 1'b1;
        tick();
        #1;
        tests_run++;
        if (ms_allowin !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_allowin: got %b expected 1", ms_allowin); end
        tests_run++;
        if (ms_to_ws_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", ms_to_ws_valid); end
        tests_run++;
        if (MEM_dest !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_dest: got %0d expected 0", MEM_dest); end
        tests_run++;
        if (MEM_result !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_result: got %h expected 0", MEM_result); end
        tests_run++;
        if (ms_load_stall !== 1'b0 || ms_ex !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_stall_ex: got %b%b expected 00", ms_load_stall, ms_ex); end
        reset = 1'b0;
        ws_allowin = 1'b1;
        ld = make_es(1'b1, 1'b1, 5'd8, 32'h88, 1'b0, 1'b1);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = ld;
        tick();
        es_to_ms_valid = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'hC0FFEE00;
        #1;
        tests_run++;
        if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== make_ws(ld, 32'hC0FFEE00)) begin
            tests_failed++;
            $display("[TB] FAIL reset_clears_cancel: got valid=%b bus=%h expected valid=1 bus=%h",
                     ms_to_ws_valid, ms_to_ws_bus, make_ws(ld, 32'hC0FFEE00));
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [118:0] a1;
        logic [118:0] a2;
        idle_inputs();
        a1 = make_es(1'b0, 1'b0, 5'd3, 32'h11, 1'b0, 1'b1);
        a2 = make_es(1'b0, 1'b0, 5'd4, 32'h22, 1'b0, 1'b1);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = a1;
        tick();
        es_to_ms_bus = a2;
        data_rdata   = 32'h0BADF00D;
        #1;
        tests_run++;
        if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== make_ws(a1, 32'h0BADF00D)) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first: got valid=%b bus=%h expected valid=1 bus=%h",
                     ms_to_ws_valid, ms_to_ws_bus, make_ws(a1, 32'h0BADF00D));
        end
        tests_run++;
        if (MEM_dest !== 5'd3 || MEM_result !== 32'h11 || ms_allowin !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first_bypass: got dest=%0d result=%h allowin=%b expected 3 11 1",
                     MEM_dest, MEM_result, ms_allowin);
        end
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        tests_run++;
        if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== make_ws(a2, 32'h0BADF00D) || MEM_dest !== 5'd4) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second: got valid=%b dest=%0d bus=%h expected valid=1 dest=4 bus=%h",
                     ms_to_ws_valid, MEM_dest, ms_to_ws_bus, make_ws(a2, 32'h0BADF00D));
        end
        tick();
        #1;
        tests_run++;
        if (ms_to_ws_valid !== 1'b0 || MEM_dest !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_drained: got valid=%b dest=%0d expected 0 0", ms_to_ws_valid, MEM_dest);
        end
        idle_inputs();
    endtask

    task automatic test_load_delay();
        logic [118:0] ld;
        idle_inputs();
        ld = make_es(1'b1, 1'b1, 5'd5, 32'h1000, 1'b0, 1'b1);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = ld;
        tick();
        es_to_ms_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_rdata = $urandom;
            #1;
            tests_run++;
            if (ms_allowin !== 1'b0 || ms_to_ws_valid !== 1'b0 || ms_load_stall !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL load_wait[%0d]: got allowin=%b valid=%b stall=%b expected 0 0 1",
                         i, ms_allowin, ms_to_ws_valid, ms_load_stall);
            end
            tick();
        end
        data_data_ok = 1'b1;
        data_rdata   = 32'hDEADBEEF;
        #1;
        tests_run++;
        if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[104:73] !== 32'hDEADBEEF ||
            ms_to_ws_bus !== make_ws(ld, 32'hDEADBEEF) || ms_allowin !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL load_done: got valid=%b allowin=%b bus=%h expected 1 1 %h",
                     ms_to_ws_valid, ms_allowin, ms_to_ws_bus, make_ws(ld, 32'hDEADBEEF));
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_load_wb_stall();
        logic [118:0] ld;
        idle_inputs();
        ld = make_es(1'b1, 1'b1, 5'd6, 32'h2000, 1'b0, 1'b1);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = ld;
        tick();
        es_to_ms_valid = 1'b0;
        ws_allowin   = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'h12345678;
        #1;
        tests_run++;
        if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stall_resp_cycle: got valid=%b allowin=%b expected 1 0", ms_to_ws_valid, ms_allowin);
        end
        tick();
        data_data_ok = 1'b0;
        data_rdata   = 32'hFFFFFFFF;
        #1;
        tests_run++;
        if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[104:73] !== 32'h12345678) begin
            tests_failed++;
            $display("[TB] FAIL stall_held: got valid=%b data=%h expected 1 12345678",
                     ms_to_ws_valid, ms_to_ws_bus[104:73]);
        end
        tick();
        ws_allowin = 1'b1;
        data_rdata = 32'h0F0F0F0F;
        #1;
        tests_run++;
        if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== make_ws(ld, 32'h12345678)) begin
            tests_failed++;
            $display("[TB] FAIL stall_release: got valid=%b bus=%h expected 1 %h",
                     ms_to_ws_valid, ms_to_ws_bus, make_ws(ld, 32'h12345678));
        end
        tick();
        #1;
        tests_run++;
        if (ms_to_ws_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_after: got valid=%b expected 0", ms_to_ws_valid); end
        idle_inputs();
    endtask

    task automatic test_flush_wait();
        logic [118:0] l1;
        logic [118:0] l2;
        idle_inputs();
        l1 = make_es(1'b1, 1'b1, 5'd10, 32'h3000, 1'b0, 1'b1);
        l2 = make_es(1'b1, 1'b1, 5'd11, 32'h3100, 1'b0, 1'b1);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = l1;
        tick();
        es_to_ms_valid = 1'b0;
        flush = 1'b1;
        #1;
        tests_run++;
        if (ms_to_ws_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_kill: got valid=%b expected 0", ms_to_ws_valid); end
        tick();
        flush = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = l2;
        #1;
        tests_run++;
        if (ms_allowin !== 1'b1 || MEM_dest !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL flush_empty: got allowin=%b dest=%0d expected 1 0", ms_allowin, MEM_dest);
        end
        tick();
        es_to_ms_valid = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'hAAAA0000;
        #1;
        tests_run++;
        if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_stale_dropped: got valid=%b allowin=%b expected 0 0", ms_to_ws_valid, ms_allowin);
        end
        tick();
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        #1;
        tests_run++;
        if (ms_to_ws_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_gap: got valid=%b expected 0", ms_to_ws_valid); end
        tick();
        data_data_ok = 1'b1;
        data_rdata   = 32'h5555FFFF;
        #1;
        tests_run++;
        if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== make_ws(l2, 32'h5555FFFF)) begin
            tests_failed++;
            $display("[TB] FAIL flush_next_load: got valid=%b bus=%h expected 1 %h",
                     ms_to_ws_valid, ms_to_ws_bus, make_ws(l2, 32'h5555FFFF));
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_flush_same_cycle();
        logic [118:0] l1;
        logic [118:0] l2;
        idle_inputs();
        l1 = make_es(1'b1, 1'b1, 5'd12, 32'h4000, 1'b0, 1'b1);
        l2 = make_es(1'b1, 1'b1, 5'd13, 32'h4100, 1'b0, 1'b1);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = l1;
        tick();
        es_to_ms_valid = 1'b0;
        flush        = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'h0BAD0BAD;
        #1;
        tests_run++;
        if (ms_to_ws_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL samecyc_kill: got valid=%b expected 0", ms_to_ws_valid); end
        tick();
        flush        = 1'b0;
        data_data_ok = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = l2;
        tick();
        es_to_ms_valid = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'h600DF00D;
        #1;
        tests_run++;
        if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== make_ws(l2, 32'h600DF00D)) begin
            tests_failed++;
            $display("[TB] FAIL samecyc_next_load: got valid=%b bus=%h expected 1 %h",
                     ms_to_ws_valid, ms_to_ws_bus, make_ws(l2, 32'h600DF00D));
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_exception();
        logic [118:0] e;
        idle_inputs();
        e = make_es(1'b0, 1'b1, 5'd9, 32'h5000, 1'b1, 1'b1);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = e;
        tick();
        es_to_ms_valid = 1'b0;
        data_rdata = 32'h13579BDF;
        #1;
        tests_run++;
        if (ms_ex !== 1'b1 || ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b1 ||
            ms_to_ws_bus !== make_ws(e, 32'h13579BDF)) begin
            tests_failed++;
            $display("[TB] FAIL ex_pass: got ex=%b valid=%b allowin=%b bus=%h expected 1 1 1 %h",
                     ms_ex, ms_to_ws_valid, ms_allowin, ms_to_ws_bus, make_ws(e, 32'h13579BDF));
        end
        tick();
        #1;
        tests_run++;
        if (ms_ex !== 1'b0 || ms_to_ws_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ex_gone: got ex=%b valid=%b expected 0 0", ms_ex, ms_to_ws_valid);
        end
        idle_inputs();
    endtask

    // Randomized traffic: the model tracks which instruction sits in MEM and the
    // in-order queue of memory responses, each tagged with the instruction it serves.
    task automatic test_random();
        resp_t        q[$];
        logic         cur_valid;
        logic [118:0] cur_bus;
        int           cur_id;
        logic         cur_got;
        logic [31:0]  cur_data;
        int           next_id;
        logic         resp_cur;
        logic         ready;
        logic         exp_valid;
        logic         exp_allowin;
        logic [31:0]  exp_data;
        logic         done;
        int           cyc;
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cur_valid = 1'b0;
        cur_bus   = '0;
        cur_id    = -1;
        cur_got   = 1'b0;
        cur_data  = '0;
        next_id   = 0;
        done      = 1'b0;
        for (cyc = 0; cyc < 460; cyc++) begin
            if (cyc < 400) begin
                ws_allowin     = ($urandom_range(0, 3) != 0);
                flush          = ($urandom_range(0, 19) == 0) && (q.size() <= 2);
                es_to_ms_valid = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 4) == 0)
                    es_to_ms_bus = make_es(1'b0, 1'b0, 5'($urandom), $urandom, 1'b1, 1'($urandom));
                else if ($urandom_range(0, 1) == 0)
                    es_to_ms_bus = make_es(1'b1, 1'($urandom), 5'($urandom), $urandom, 1'b0, 1'($urandom));
                else
                    es_to_ms_bus = make_es(1'b0, 1'b0, 5'($urandom), $urandom, 1'b0, 1'b1);
            end else begin
                ws_allowin     = 1'b1;
                flush          = 1'b0;
                es_to_ms_valid = 1'b0;
                if (q.size() == 0 && !cur_valid) begin
                    done = 1'b1;
                    break;
                end
            end
            if (q.size() > 0 && q[0].ready <= cyc) begin
                data_data_ok = 1'b1;
                data_rdata   = q[0].data;
            end else begin
                data_data_ok = 1'b0;
                data_rdata   = $urandom;
            end
            #1;
            resp_cur    = data_data_ok && cur_valid && (q[0].id == cur_id);
            ready       = !cur_bus[118] || cur_got || resp_cur;
            exp_valid   = cur_valid && ready && !flush;
            exp_allowin = !cur_valid || (ready && ws_allowin);
            exp_data    = (cur_bus[118] && cur_got) ? cur_data : data_rdata;
            tests_run++;
            if (ms_allowin !== exp_allowin) begin
                tests_failed++;
                $display("[TB] FAIL rnd_allowin cyc=%0d: got %b expected %b", cyc, ms_allowin, exp_allowin);
            end
            tests_run++;
            if (ms_to_ws_valid !== exp_valid) begin
                tests_failed++;
                $display("[TB] FAIL rnd_valid cyc=%0d: got %b expected %b", cyc, ms_to_ws_valid, exp_valid);
            end
            if (exp_valid) begin
                tests_run++;
                if (ms_to_ws_bus !== make_ws(cur_bus, exp_data)) begin
                    tests_failed++;
                    $display("[TB] FAIL rnd_bus cyc=%0d: got %h expected %h", cyc, ms_to_ws_bus, make_ws(cur_bus, exp_data));
                end
            end
            tests_run++;
            if (MEM_dest !== (cur_valid ? cur_bus[68:64] : 5'd0) ||
                ms_ex !== (cur_valid & cur_bus[70]) || ms_load_stall !== (cur_valid & cur_bus[117]) ||
                (cur_valid && MEM_result !== cur_bus[63:32])) begin
                tests_failed++;
                $display("[TB] FAIL rnd_id_info cyc=%0d: got dest=%0d ex=%b stall=%b result=%h expected dest=%0d ex=%b stall=%b result=%h",
                         cyc, MEM_dest, ms_ex, ms_load_stall, MEM_result,
                         cur_valid ? cur_bus[68:64] : 5'd0, cur_valid & cur_bus[70],
                         cur_valid & cur_bus[117], cur_bus[63:32]);
            end
            if (resp_cur) begin
                cur_got  = 1'b1;
                cur_data = data_rdata;
            end
            if (data_data_ok) void'(q.pop_front());
            if (flush) begin
                cur_valid = 1'b0;
            end else if (exp_allowin) begin
                cur_valid = es_to_ms_valid;
                if (es_to_ms_valid) begin
                    cur_bus = es_to_ms_bus;
                    cur_id  = next_id;
                    cur_got = 1'b0;
                    next_id++;
                    if (es_to_ms_bus[118])
                        q.push_back('{id: cur_id, data: $urandom, ready: cyc + 1 + int'($urandom_range(0, 3))});
                end
            end
            tick();
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("[TB] FAIL rnd_drain_timeout: got pending=%0d busy=%b expected 0 0", q.size(), cur_valid);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_back_to_back();
        test_load_delay();
        test_load_wb_stall();
        test_flush_wait();
        test_flush_same_cycle();
        test_exception();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Pipeline MEM stage, between the EX stage and `wb_stage`. It holds one instruction, waits for the data-memory response of any load or store issued by EX, and merges the load data into the 150-bit MS→WS bus. It buffers a response that arrives while WB is stalled, and drops responses orphaned by a pipeline flush. It also drives bypass and stall information to ID.

## Interface
Parameters: none. Bus widths come from `global_defines.vh`: `ES_TO_MS_BUS_WD` = 119, `MS_TO_WS_BUS_WD` = 150.

- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- flush  input  1  exception/eret flush; kills the MEM instruction
- es_to_ms_valid  input  1  EX holds a valid instruction for MEM
- es_to_ms_bus  input  119  `{mem_req[118], res_from_mem[117], mem_inst[116:105], rt_value[104:73], rdata_type[72:71], ex[70], gr_we[69], dest[68:64], result[63:32], pc[31:0]}`
- ms_allowin  output  1  MEM accepts from EX this cycle
- data_data_ok  input  1  data-memory response strobe (one per issued request, in order)
- data_rdata  input  32  response data, valid with data_data_ok
- ws_allowin  input  1  WB accepts this cycle
- ms_to_ws_valid  output  1  valid toward WB
- ms_to_ws_bus  output  150  `{res_from_mem, mem_inst, rt_value, data_rdata, rdata_type, ex, gr_we, dest, result, pc}`, in that order, MSB first
- MEM_dest  output  5  `dest & {5{ms_valid}}`, for ID bypass
- MEM_result  output  32  `result` field, for ID bypass
- ms_load_stall  output  1  `ms_valid & res_from_mem`; ID stalls on a dest match
- ms_ex  output  1  `ms_valid & ex`; EX suppresses request issue

## Operation
- State: `ms_valid`, bus register `bus_r` (119 b), `rbuf_valid`, `rbuf` (32 b), `cancel_cnt` (2 b).
- `ms_valid`:
  - `flush` → 0.
  - Else, when `ms_allowin` → `es_to_ms_valid`.
- `bus_r` loads `es_to_ms_bus` when `es_to_ms_valid & ms_allowin & !flush`.
- `mem_req` is 1 only for loads and stores that EX actually issued. EX never issues a request for an instruction with `ex` set.
- A response is "own" when `data_data_ok & cancel_cnt==0`. A response with `cancel_cnt!=0` is stale: `cancel_cnt` decrements and the response is ignored entirely.
- `got_data = rbuf_valid | own`.
- `ms_ready_go = !mem_req | got_data`.
- `ms_allowin = !ms_valid | (ms_ready_go & ws_allowin)`.
- `ms_to_ws_valid = ms_valid & ms_ready_go & !flush`.
- Data field = `rbuf_valid ? rbuf : data_rdata`.
- Buffering:
  - `own & ms_valid & mem_req & !rbuf_valid & !ws_allowin & !flush` → `rbuf <= data_rdata`, `rbuf_valid <= 1`.
  - `rbuf_valid` clears on handoff (`ms_to_ws_valid & ws_allowin`) or on `flush`.
- Cancel tracking:
  - `flush & ms_valid & mem_req & !got_data` → `cancel_cnt++`.
  - Same cycle as an own response → no increment; the response is consumed and discarded.
  - Simultaneous increment and stale decrement → net 0.
  - Saturates at 3; reaching it is a design error, flagged by assertion.
- A request issued by EX in the flush cycle is accounted for by EX, not here.
- Reset values: `ms_valid` 0, `bus_r` 0, `rbuf_valid` 0, `rbuf` 0, `cancel_cnt` 0. Resulting outputs: `ms_allowin` 1, `ms_to_ws_valid` 0, `MEM_dest` 0, `MEM_result` 0, `ms_load_stall` 0, `ms_ex` 0.

## Timing
- Non-memory instruction, or one with `ex` set:
  - Accepted at edge T.
  - `ms_to_ws_valid` in cycle T (combinational); leaves at edge T+1 if `ws_allowin`.
- Load or store:
  - Waits in MEM until the own `data_data_ok` (cycle T+k, k≥0 after acceptance).
  - `ms_to_ws_valid` in that same cycle; `data_rdata` passes straight through with zero added latency.
- WB stalled at the response cycle: data is held in `rbuf`. Later responses are never needed, because only one request per MEM instruction exists.
- `reset` mid-wait drops everything, including `cancel_cnt`. The memory side is reset in the same cycle.
- Throughput: one instruction per cycle when responses are immediate and WB is ready.

## Test plan
- Back-to-back ALU ops, `result` 0x11, 0x22, `dest` 3, 4: `ms_to_ws_valid` every cycle, buses in order. `MEM_dest` is 3 then 4.
- Load, `data_data_ok` 3 cycles after acceptance with `data_rdata` 0xDEADBEEF: `ms_allowin` 0 for 3 cycles. Then `ms_to_ws_valid`=1 and bus bits [104:73] = 0xDEADBEEF.
- Load response 0x12345678 while `ws_allowin`=0 for 2 cycles: data held in `rbuf`. Forwarded when `ws_allowin` rises, with `data_data_ok` no longer high.
- `flush` while a load waits: `ms_valid`→0, `cancel_cnt`→1. Next instruction (a load) is accepted. The first `data_data_ok` (0xAAAA0000) is dropped and `cancel_cnt`→0. The second (0x5555FFFF) completes the new load.
- `flush` in the same cycle as the own `data_data_ok`: `cancel_cnt` stays 0, no `ms_to_ws_valid`. The next response goes to the next load.
- Instruction with `ex`=1, `gr_we`=1: passes in one cycle, `ms_ex`=1, no wait on `data_data_ok`.
